lifo_stack: RTL and testbench

Parametrised LIFO stack, the successor to the accumulator processor's fixed stack. It supports arbitrary depth, including non-power-of-two, and simultaneous push/pop (replace-top). It also adds an exposed occupancy count, an almost-full threshold, a flush, and sticky error reporting. It sits beside the controller as the call/operand stack and is driven directly by controller strobes.

---
 rtl/stack_pkg.sv | 26 ++
 rtl/lifo_stack_if.sv | 42 ++++
 rtl/stack_ptr.sv | 61 ++++++
 rtl/lifo_stack.sv | 158 +++++++++++++++
 tb/tb_lifo_stack.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// ---------------------------------------------------------------------------
// stack_pkg
// Shared types and helpers for the lifo_stack block.
//   op_t       : per-cycle stack operation decoded from {push, pop}
//   cnt_width  : width of an occupancy counter that can hold 0..depth
//   decode_op  : {push, pop} -> op_t
// ---------------------------------------------------------------------------
package stack_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_REPL = 2'b11     // push and pop together: replace the top entry
    } op_t;

    // The counter must represent DEPTH itself, not just DEPTH-1.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic op_t decode_op(input logic push, input logic pop);
        return op_t'({push, pop});
    endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// ---------------------------------------------------------------------------
// lifo_stack_if
// Controller <-> stack signal bundle.
//   master : controller side (drives push/pop/flush/data_in)
//   slave  : stack side (drives data_out, dout_valid, top, count, status)
// Parameters: WIDTH (data width), DEPTH (entries); CW is derived.
// ---------------------------------------------------------------------------
interface lifo_stack_if
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = cnt_width(DEPTH);

    logic             push;
    logic             pop;
    logic             flush;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             dout_valid;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, flush, data_in,
        input  data_out, dout_valid, top, count,
        input  full, empty, almost_full, overflow, underflow
    );

    modport slave (
        input  push, pop, flush, data_in,
        output data_out, dout_valid, top, count,
        output full, empty, almost_full, overflow, underflow
    );

endinterface

// File: rtl/stack_ptr.sv
// ---------------------------------------------------------------------------
// stack_ptr
// Stack pointer (== occupancy count) with full / empty / almost_full decode.
// Ports:
//   clk, clr       : clock, synchronous active-high clear
//   flush_i        : zero the count (beats inc/dec)
//   inc_i, dec_i   : accepted push / accepted pop (never both)
//   count_o        : occupancy 0..DEPTH
//   full_o, empty_o, almost_full_o : combinational decodes of count_o
// ---------------------------------------------------------------------------
module stack_ptr
    import stack_pkg::*;
#(
    parameter int  DEPTH    = 4,
    parameter int  AF_LEVEL = DEPTH - 1,
    localparam int CW       = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          flush_i,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          almost_full_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // NOTE: every variable written in an always_comb gets a default on the
    // first line, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + 1'b1;
        end else if (dec_i) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Decoded straight from the count so they can never disagree with it.
    assign count_o       = count_q;
    assign full_o        = (count_q == CW'(DEPTH));
    assign empty_o       = (count_q == '0);
    assign almost_full_o = (count_q >= CW'(AF_LEVEL));

endmodule

// File: rtl/lifo_stack.sv
// ---------------------------------------------------------------------------
// lifo_stack
// Parametrised LIFO call/operand stack with replace-top (push+pop), flush,
// occupancy count, almost-full threshold and optional sticky error flags.
// Ports:
//   clk  : rising-edge clock
//   clr  : synchronous active-high clear (beats flush, which beats push/pop)
//   bus  : lifo_stack_if.slave -- push/pop/flush/data_in in; data_out,
//          dout_valid, top, count, full, empty, almost_full, overflow,
//          underflow out
// Build option: define LIFO_ERR_EN to implement overflow/underflow as sticky
// registers; otherwise both read 0 and dropped operations are silent.
// ---------------------------------------------------------------------------
module lifo_stack
    import stack_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic        clk,
    input  logic        clr,
    lifo_stack_if.slave bus
);

    localparam int CW = cnt_width(DEPTH);
    localparam int AW = $clog2(DEPTH);

    op_t           op;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          push_ok;
    logic          pop_ok;
    logic          repl_ok;
    logic [AW-1:0] push_idx;
    logic [AW-1:0] top_idx;
    logic [WIDTH-1:0] top_entry;
    logic          mem_we;
    logic [AW-1:0] wr_idx;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] data_out_q;
    logic [WIDTH-1:0] data_out_d;
    logic             dout_valid_q;
    logic             dout_valid_d;

    assign op = decode_op(bus.push, bus.pop);

    // Accepted operations; a flush in the same cycle discards all of them.
    assign push_ok = !bus.flush && (op == OP_PUSH) && !full;
    assign pop_ok  = !bus.flush && (op == OP_POP)  && !empty;
    assign repl_ok = !bus.flush && (op == OP_REPL) && !empty;

    stack_ptr #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) u_ptr (
        .clk           (clk),
        .clr           (clr),
        .flush_i       (bus.flush),
        .inc_i         (push_ok),
        .dec_i         (pop_ok),
        .count_o       (count),
        .full_o        (full),
        .empty_o       (empty),
        .almost_full_o (almost_full)
    );

    // Indices are only used when in range: push_idx when not full, top_idx
    // when not empty, so the truncation to AW bits is safe.
    assign push_idx  = AW'(count);
    assign top_idx   = AW'(count - 1'b1);
    assign top_entry = mem_q[top_idx];

    // Replace-top overwrites the current top slot; a plain push fills the
    // next free slot.
    assign mem_we = !clr && (push_ok || repl_ok);
    assign wr_idx = repl_ok ? top_idx : push_idx;

    // NOTE: the storage array has no reset; its contents are don't-care once
    // count is cleared, and leaving it unreset keeps it a plain register file.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_idx] <= bus.data_in;
        end
    end

    always_comb begin
        data_out_d   = data_out_q;
        dout_valid_d = 1'b0;
        if (!bus.flush) begin
            unique case (op)
                OP_POP: begin
                    if (!empty) begin
                        data_out_d   = top_entry;
                        dout_valid_d = 1'b1;
                    end
                end
                OP_REPL: begin
                    // Empty stack: the pushed value passes straight through.
                    data_out_d   = empty ? bus.data_in : top_entry;
                    dout_valid_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            data_out_q   <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            dout_valid_q <= dout_valid_d;
        end
    end

`ifdef LIFO_ERR_EN
    logic overflow_q;
    logic overflow_d;
    logic underflow_q;
    logic underflow_d;

    // Sticky until clr; flush holds them and suppresses new errors.
    always_comb begin
        overflow_d  = overflow_q  | (!bus.flush && (op == OP_PUSH) && full);
        underflow_d = underflow_q | (!bus.flush && (op == OP_POP)  && empty);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    assign bus.data_out    = data_out_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.top         = empty ? '0 : top_entry;
    assign bus.count       = count;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almost_full = almost_full;

endmodule

// File: tb/tb_lifo_stack.sv
// ---------------------------------------------------------------------------
// tb_lifo_stack
// Self-checking bench for lifo_stack (DEPTH=5, AF_LEVEL=4, WIDTH=8).
// Directed scenarios followed by random traffic checked against a
// queue-based model of the stack. Honours LIFO_ERR_EN for the error flags.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lifo_stack;
    import stack_pkg::*;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 5;
    localparam int AF_LEVEL = 4;
`ifdef LIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr;

    lifo_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    lifo_stack #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue whose back is the top of stack.
    logic [WIDTH-1:0] stk [$];
    logic [WIDTH-1:0] m_dout;
    bit               m_valid;
    bit               m_ovf;
    bit               m_unf;

    task automatic model_step(input bit p, input bit q, input bit f, input bit c,
                              input logic [WIDTH-1:0] d);
        if (c) begin
            stk.delete(); m_dout = '0; m_valid = 0; m_ovf = 0; m_unf = 0;
        end else if (f) begin
            stk.delete(); m_valid = 0;
        end else if (p && q) begin
            m_valid = 1;
            if (stk.size() == 0) m_dout = d;
            else begin m_dout = stk.pop_back(); stk.push_back(d); end
        end else if (p) begin
            m_valid = 0;
            if (stk.size() < DEPTH) stk.push_back(d);
            else m_ovf = m_ovf | ERR_EN;
        end else if (q) begin
            if (stk.size() > 0) begin m_dout = stk.pop_back(); m_valid = 1; end
            else begin m_valid = 0; m_unf = m_unf | ERR_EN; end
        end else begin
            m_valid = 0;
        end
    endtask

    function automatic logic [WIDTH-1:0] m_top();
        return (stk.size() == 0) ? '0 : stk[stk.size() - 1];
    endfunction

    // One clock: apply inputs, advance the model, sample 1ns after the edge.
    task automatic drive(input bit p, input bit q, input bit f, input bit c,
                         input logic [WIDTH-1:0] d);
        clr = c; bus.push = p; bus.pop = q; bus.flush = f; bus.data_in = d;
        model_step(p, q, f, c, d);
        @(posedge clk);
        #1;
        clr = 0; bus.push = 0; bus.pop = 0; bus.flush = 0;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 1, 8'h00);
        n_checks++; if (bus.count !== 0)          begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        n_checks++; if (bus.empty !== 1'b1)       begin n_fail++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
        n_checks++; if (bus.full !== 1'b0)        begin n_fail++; $display("FAIL reset_full got=%b exp=0", bus.full); end
        n_checks++; if (bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got=%b exp=0", bus.almost_full); end
        n_checks++; if (bus.top !== 8'h00)        begin n_fail++; $display("FAIL reset_top got=%0h exp=0", bus.top); end
        n_checks++; if (bus.data_out !== 8'h00)   begin n_fail++; $display("FAIL reset_dout got=%0h exp=0", bus.data_out); end
        n_checks++; if (bus.dout_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.dout_valid); end
        n_checks++; if (bus.overflow !== 1'b0)    begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
        n_checks++; if (bus.underflow !== 1'b0)   begin n_fail++; $display("FAIL reset_unf got=%b exp=0", bus.underflow); end
    endtask

    task automatic test_push_pop();
        logic [WIDTH-1:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        drive(0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, vals[i]);
            n_checks++; if (bus.top !== vals[i]) begin n_fail++; $display("FAIL push_top[%0d] got=%0h exp=%0h", i, bus.top, vals[i]); end
        end
        n_checks++; if (bus.count !== 3) begin n_fail++; $display("FAIL push_count got=%0d exp=3", bus.count); end
        for (int i = 2; i >= 0; i--) begin
            drive(0, 1, 0, 0, 8'h00);
            n_checks++; if (bus.data_out !== vals[i]) begin n_fail++; $display("FAIL pop_dout[%0d] got=%0h exp=%0h", i, bus.data_out, vals[i]); end
            n_checks++; if (bus.dout_valid !== 1'b1)  begin n_fail++; $display("FAIL pop_valid[%0d] got=%b exp=1", i, bus.dout_valid); end
        end
        drive(0, 0, 0, 0, 8'h00);
        n_checks++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL pop_valid_pulse got=%b exp=0", bus.dout_valid); end
        n_checks++; if (bus.empty !== 1'b1)      begin n_fail++; $display("FAIL pop_empty got=%b exp=1", bus.empty); end
        n_checks++; if (bus.top !== 8'h00)       begin n_fail++; $display("FAIL pop_top_empty got=%0h exp=0", bus.top); end
    endtask

    task automatic test_overflow();
        drive(0, 0, 0, 1, 8'h00);
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1, 0, 0, 0, 8'(8'h40 + i));
            n_checks++; if (bus.almost_full !== (i >= AF_LEVEL)) begin n_fail++; $display("FAIL af_at_%0d got=%b exp=%b", i, bus.almost_full, (i >= AF_LEVEL)); end
            n_checks++; if (bus.full !== (i == DEPTH))           begin n_fail++; $display("FAIL full_at_%0d got=%b exp=%b", i, bus.full, (i == DEPTH)); end
        end
        drive(1, 0, 0, 0, 8'hEE);
        n_checks++; if (bus.count !== DEPTH)     begin n_fail++; $display("FAIL ovf_count got=%0d exp=%0d", bus.count, DEPTH); end
        n_checks++; if (bus.top !== 8'h45)       begin n_fail++; $display("FAIL ovf_top got=%0h exp=45", bus.top); end
        n_checks++; if (bus.overflow !== ERR_EN) begin n_fail++; $display("FAIL ovf_flag got=%b exp=%b", bus.overflow, ERR_EN); end
        drive(0, 1, 0, 0, 8'h00);
        drive(0, 1, 0, 0, 8'h00);
        n_checks++; if (bus.data_out !== 8'h44)  begin n_fail++; $display("FAIL ovf_pop_dout got=%0h exp=44", bus.data_out); end
        n_checks++; if (bus.overflow !== ERR_EN) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=%b", bus.overflow, ERR_EN); end
        drive(0, 0, 0, 1, 8'h00);
        n_checks++; if (bus.overflow !== 1'b0)   begin n_fail++; $display("FAIL ovf_clr got=%b exp=0", bus.overflow); end
    endtask

    task automatic test_underflow();
        drive(0, 0, 0, 1, 8'h00);
        drive(0, 1, 0, 0, 8'h00);
        n_checks++; if (bus.dout_valid !== 1'b0)  begin n_fail++; $display("FAIL unf_valid got=%b exp=0", bus.dout_valid); end
        n_checks++; if (bus.count !== 0)          begin n_fail++; $display("FAIL unf_count got=%0d exp=0", bus.count); end
        n_checks++; if (bus.underflow !== ERR_EN) begin n_fail++; $display("FAIL unf_flag got=%b exp=%b", bus.underflow, ERR_EN); end
        drive(0, 0, 0, 1, 8'h00);
        drive(1, 1, 0, 0, 8'h5A);
        n_checks++; if (bus.data_out !== 8'h5A)  begin n_fail++; $display("FAIL pass_dout got=%0h exp=5a", bus.data_out); end
        n_checks++; if (bus.dout_valid !== 1'b1) begin n_fail++; $display("FAIL pass_valid got=%b exp=1", bus.dout_valid); end
        n_checks++; if (bus.count !== 0)         begin n_fail++; $display("FAIL pass_count got=%0d exp=0", bus.count); end
        n_checks++; if (bus.underflow !== 1'b0 || bus.overflow !== 1'b0)
            begin n_fail++; $display("FAIL pass_err got=%b%b exp=00", bus.overflow, bus.underflow); end
    endtask

    task automatic test_replace_full();
        drive(0, 0, 0, 1, 8'h00);
        for (int i = 0; i < DEPTH - 1; i++) drive(1, 0, 0, 0, 8'(8'h10 + i));
        drive(1, 0, 0, 0, 8'h44);
        drive(1, 1, 0, 0, 8'h99);
        n_checks++; if (bus.data_out !== 8'h44)  begin n_fail++; $display("FAIL repl_dout got=%0h exp=44", bus.data_out); end
        n_checks++; if (bus.top !== 8'h99)       begin n_fail++; $display("FAIL repl_top got=%0h exp=99", bus.top); end
        n_checks++; if (bus.count !== DEPTH)     begin n_fail++; $display("FAIL repl_count got=%0d exp=%0d", bus.count, DEPTH); end
        n_checks++; if (bus.overflow !== 1'b0)   begin n_fail++; $display("FAIL repl_ovf got=%b exp=0", bus.overflow); end
        drive(0, 1, 0, 0, 8'h00);
        n_checks++; if (bus.data_out !== 8'h99)  begin n_fail++; $display("FAIL repl_pop got=%0h exp=99", bus.data_out); end
    endtask

    task automatic test_flush_clr();
        drive(0, 0, 0, 1, 8'h00);
        drive(0, 1, 0, 0, 8'h00);                  // underflow, to see it held
        drive(1, 0, 0, 0, 8'hA1);
        drive(1, 0, 0, 0, 8'hA2);
        drive(1, 0, 0, 0, 8'hA3);
        drive(1, 0, 1, 0, 8'h77);
        n_checks++; if (bus.count !== 0)          begin n_fail++; $display("FAIL flush_count got=%0d exp=0", bus.count); end
        n_checks++; if (bus.top !== 8'h00)        begin n_fail++; $display("FAIL flush_top got=%0h exp=0", bus.top); end
        n_checks++; if (bus.dout_valid !== 1'b0)  begin n_fail++; $display("FAIL flush_valid got=%b exp=0", bus.dout_valid); end
        n_checks++; if (bus.underflow !== ERR_EN) begin n_fail++; $display("FAIL flush_hold_unf got=%b exp=%b", bus.underflow, ERR_EN); end
        drive(1, 0, 0, 0, 8'hB1);
        drive(1, 0, 0, 0, 8'hB2);
        drive(1, 0, 0, 1, 8'hB3);                  // clr mid-burst beats push
        n_checks++; if (bus.count !== 0)          begin n_fail++; $display("FAIL clr_count got=%0d exp=0", bus.count); end
        n_checks++; if (bus.top !== 8'h00)        begin n_fail++; $display("FAIL clr_top got=%0h exp=0", bus.top); end
        n_checks++; if (bus.data_out !== 8'h00)   begin n_fail++; $display("FAIL clr_dout got=%0h exp=0", bus.data_out); end
        n_checks++; if (bus.underflow !== 1'b0)   begin n_fail++; $display("FAIL clr_unf got=%b exp=0", bus.underflow); end
        n_checks++; if (bus.empty !== 1'b1)       begin n_fail++; $display("FAIL clr_empty got=%b exp=1", bus.empty); end
    endtask

    task automatic test_random();
        bit p, q, f, c;
        logic [WIDTH-1:0] d;
        drive(0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 600; i++) begin
            c = ($urandom_range(0, 59) == 0);
            f = ($urandom_range(0, 29) == 0);
            p = ($urandom_range(0, 9) < 6);
            q = ($urandom_range(0, 9) < 5);
            d = 8'($urandom);
            drive(p, q, f, c, d);
            n_checks++; if (bus.count !== stk.size())  begin n_fail++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, bus.count, stk.size()); end
            n_checks++; if (bus.top !== m_top())       begin n_fail++; $display("FAIL rnd_top[%0d] got=%0h exp=%0h", i, bus.top, m_top()); end
            n_checks++; if (bus.data_out !== m_dout)   begin n_fail++; $display("FAIL rnd_dout[%0d] got=%0h exp=%0h", i, bus.data_out, m_dout); end
            n_checks++; if (bus.dout_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, bus.dout_valid, m_valid); end
            n_checks++; if (bus.full !== (stk.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full[%0d] got=%b", i, bus.full); end
            n_checks++; if (bus.empty !== (stk.size() == 0))    begin n_fail++; $display("FAIL rnd_empty[%0d] got=%b", i, bus.empty); end
            n_checks++; if (bus.almost_full !== (stk.size() >= AF_LEVEL)) begin n_fail++; $display("FAIL rnd_af[%0d] got=%b", i, bus.almost_full); end
            n_checks++; if (bus.overflow !== m_ovf)    begin n_fail++; $display("FAIL rnd_ovf[%0d] got=%b exp=%b", i, bus.overflow, m_ovf); end
            n_checks++; if (bus.underflow !== m_unf)   begin n_fail++; $display("FAIL rnd_unf[%0d] got=%b exp=%b", i, bus.underflow, m_unf); end
        end
    endtask

    initial begin
        clr = 1'b1; bus.push = 0; bus.pop = 0; bus.flush = 0; bus.data_in = '0;
        m_dout = '0; m_valid = 0; m_ovf = 0; m_unf = 0;
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_replace_full();
        test_flush_clr();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
